// File: rtl/internal_bus_pkg.sv
// ---------------------------------------------------------------------------
// internal_bus_pkg
// Shared definitions for the internal register-transfer bus:
//   - bus_state_t      : transfer FSM state encoding (IDLE / SAMPLE / COMMIT)
//   - DEFAULT_DATA_W   : default bus width in bits
//   - DEFAULT_N_PORTS  : default number of attached register ports
// ---------------------------------------------------------------------------
package internal_bus_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_N_PORTS = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_COMMIT = 2'd2
    } bus_state_t;

endpackage

// File: rtl/internal_bus_src_mux.sv
// ---------------------------------------------------------------------------
// bus_src_mux
// Combinational source selection for the internal bus.
// Ports:
//   src_data  in  N_PORTS*DATA_W  packed port outputs, port k at [k*DATA_W +: DATA_W]
//   sel       in  SEL_W           source index
//   data_out  out DATA_W          selected port word; zero for any index that
//                                 is not a real port (the caller decides what
//                                 a NO_PORT source means)
// ---------------------------------------------------------------------------
module bus_src_mux
    import internal_bus_pkg::*;
#(
    parameter int  DATA_W  = DEFAULT_DATA_W,
    parameter int  N_PORTS = DEFAULT_N_PORTS,
    localparam int SEL_W   = $clog2(N_PORTS + 1)
) (
    input  logic [N_PORTS*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         data_out
);

    logic [DATA_W-1:0] port_word [N_PORTS];

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
            assign port_word[gi] = src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Compare-and-pick instead of a direct array index so that selects beyond
    // the last port never produce an out-of-range read.
    always_comb begin
        data_out = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (sel == SEL_W'(k)) begin
                data_out = port_word[k];
            end
        end
    end

endmodule

// File: rtl/internal_bus.sv
// ---------------------------------------------------------------------------
// internal_bus
// Three-phase register-to-register transfer bus. A request is accepted in
// IDLE, the selected source is latched onto the bus on the edge leaving
// SAMPLE, and the selected sink receives a one-cycle write strobe in COMMIT.
// Ports:
//   phi2        in   1               clock (rising edge)
//   reset       in   1               synchronous, active-high reset
//   xfer_valid  in   1               transfer request
//   xfer_ready  out  1               high in IDLE only
//   rd_sel      in   SEL_W           source port, N_PORTS = NO_PORT
//   wr_sel      in   SEL_W           sink port,   N_PORTS = NO_PORT
//   src_data    in   N_PORTS*DATA_W  packed port outputs
//   bus_data    out  DATA_W          registered bus latch
//   wr_strobe   out  N_PORTS         one-hot sink write enable (COMMIT only)
//   sel_err     out  1               one-cycle pulse after an illegal request
//   xfer_count  out  16              completed transfers, wraps at 0xFFFF
// Build option:
//   INTERNAL_BUS_PRECHARGE_EN  when defined, a NO_PORT source loads all ones
//                              (precharged bus); otherwise the bus holds.
// ---------------------------------------------------------------------------
module internal_bus
    import internal_bus_pkg::*;
#(
    parameter int  DATA_W  = DEFAULT_DATA_W,
    parameter int  N_PORTS = DEFAULT_N_PORTS,
    localparam int SEL_W   = $clog2(N_PORTS + 1)
) (
    input  logic                      phi2,
    input  logic                      reset,
    input  logic                      xfer_valid,
    output logic                      xfer_ready,
    input  logic [SEL_W-1:0]          rd_sel,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [N_PORTS*DATA_W-1:0] src_data,
    output logic [DATA_W-1:0]         bus_data,
    output logic [N_PORTS-1:0]        wr_strobe,
    output logic                      sel_err,
    output logic [15:0]               xfer_count
);

    localparam logic [SEL_W-1:0] NO_PORT = SEL_W'(N_PORTS);

    bus_state_t          state_reg, state_next;
    logic [SEL_W-1:0]    rd_sel_reg, wr_sel_reg;
    logic [DATA_W-1:0]   bus_data_reg;
    logic [N_PORTS-1:0]  wr_strobe_reg;
    logic                sel_err_reg, sel_err_next;
    logic [15:0]         count_reg;
    logic                accept;
    logic [DATA_W-1:0]   mux_data;
    logic [N_PORTS-1:0]  strobe_decode;
    logic                sel_illegal;

    bus_src_mux #(
        .DATA_W  (DATA_W),
        .N_PORTS (N_PORTS)
    ) u_src_mux (
        .src_data (src_data),
        .sel      (rd_sel_reg),
        .data_out (mux_data)
    );

    // One-hot sink decode; NO_PORT matches no bit, so it yields all zeros.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_strobe
            assign strobe_decode[gi] = (wr_sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign sel_illegal = (rd_sel > NO_PORT) || (wr_sel > NO_PORT);

    always_comb begin
        state_next   = state_reg;
        xfer_ready   = (state_reg == ST_IDLE);
        accept       = 1'b0;
        sel_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (xfer_valid) begin
                    if (sel_illegal) begin
                        sel_err_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rd_sel_reg    <= NO_PORT;
            wr_sel_reg    <= NO_PORT;
            bus_data_reg  <= '0;
            wr_strobe_reg <= '0;
            sel_err_reg   <= 1'b0;
            count_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            sel_err_reg <= sel_err_next;

            if (accept) begin
                rd_sel_reg <= rd_sel;
                wr_sel_reg <= wr_sel;
            end

            // The strobe register is loaded on the same edge that enters
            // COMMIT, so it is high for exactly the COMMIT cycle.
            if (state_reg == ST_SAMPLE) begin
                wr_strobe_reg <= strobe_decode;
                if (rd_sel_reg == NO_PORT) begin
`ifdef INTERNAL_BUS_PRECHARGE_EN
                    bus_data_reg <= '1;
`else
                    bus_data_reg <= bus_data_reg;
`endif
                end else begin
                    bus_data_reg <= mux_data;
                end
            end else begin
                wr_strobe_reg <= '0;
            end

            if (state_reg == ST_COMMIT) begin
                count_reg <= count_reg + 16'd1;
            end
        end
    end

    assign bus_data   = bus_data_reg;
    assign wr_strobe  = wr_strobe_reg;
    assign sel_err    = sel_err_reg;
    assign xfer_count = count_reg;

endmodule
